// File: rtl/fetch_queue.sv
// fetch_queue
//   IF/ID boundary: a DEPTH-entry circular instruction queue feeding the
//   ID-facing output register. Fetch keeps running while ID stalls, a bubble
//   (all zeros) is presented when no instruction is available, and a flush
//   discards everything held in the queue and in the output register.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   rst       : synchronous, active-high reset (takes priority over flush)
//   if_valid  : IF presents an instruction this cycle
//   if_pc     : PC of the presented instruction
//   if_inst   : presented instruction word
//   if_ready  : queue can accept (count != DEPTH), from registered state only
//   id_stall  : ID holds; the output register keeps its value
//   flush     : discard queue and output register, drop a concurrent fetch
//   id_valid  : id_pc/id_inst carry a real instruction
//   id_pc     : PC to ID, zero on a bubble
//   id_inst   : instruction to ID, zero on a bubble
//   count     : queue occupancy, not counting the output register
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [INST_W-1:0]          if_inst,
    output logic                       if_ready,
    input  logic                       id_stall,
    input  logic                       flush,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q,    id_pc_d;
    logic [INST_W-1:0] id_inst_q,  id_inst_d;

    logic push;
    logic pop;
    logic bypass;
    logic wr_en;

    // Full/empty come from the registered count only, so if_ready has no
    // combinational dependence on id_stall or flush.
    assign if_ready = (count_q != FULL_CNT);

    always_comb begin
        push   = if_valid && if_ready && !flush;
        pop    = !id_stall && (count_q != '0) && !flush;
        // An empty queue with ID free lets the fetch skip the queue entirely.
        bypass = (BYPASS != 0) && !id_stall && (count_q == '0) && push;
        wr_en  = push && !bypass;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;

        if (flush) begin
            // Bubble is forced even while ID is stalled.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_inst_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);

            if (!id_stall) begin
                if (pop) begin
                    {id_pc_d, id_inst_d} = mem_q[rd_ptr_q];
                    id_valid_d           = 1'b1;
                end else if (bypass) begin
                    id_pc_d    = if_pc;
                    id_inst_d  = if_inst;
                    id_valid_d = 1'b1;
                end else begin
                    id_pc_d    = '0;
                    id_inst_d  = '0;
                    id_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    // Storage is never read before being written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {if_pc, if_inst};
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: drives one BYPASS=1 and one BYPASS=0 instance with the
// same inputs and compares both against a queue-level model every cycle,
// with directed sections pinned by literal expectations.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          if_valid = 1'b0;
    logic [AW-1:0] if_pc = '0;
    logic [IW-1:0] if_inst = '0;
    logic          id_stall = 1'b0;
    logic          flush = 1'b0;

    logic          rdy0, rdy1, vld0, vld1;
    logic [AW-1:0] pc0, pc1;
    logic [IW-1:0] inst0, inst1;
    logic [CW-1:0] cnt0, cnt1;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .INST_W(IW), .BYPASS(0)) u_q0 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_ready(rdy0), .id_stall(id_stall), .flush(flush), .id_valid(vld0),
        .id_pc(pc0), .id_inst(inst0), .count(cnt0)
    );

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .INST_W(IW), .BYPASS(1)) u_q1 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_ready(rdy1), .id_stall(id_stall), .flush(flush), .id_valid(vld1),
        .id_pc(pc1), .id_inst(inst1), .count(cnt1)
    );

    // Model: index 0 is BYPASS=0, index 1 is BYPASS=1.
    logic [63:0] mq [2][64];
    int          msz [2];
    logic        mv [2];
    logic [63:0] mout [2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst || flush) begin
                msz[i]  = 0;
                mv[i]   = 1'b0;
                mout[i] = '0;
            end else begin
                logic acc;
                logic took;
                acc  = if_valid && (msz[i] != DEPTH);
                took = 1'b0;
                if (!id_stall) begin
                    if (msz[i] > 0) begin
                        mout[i] = mq[i][0];
                        mv[i]   = 1'b1;
                        for (int j = 0; j < msz[i] - 1; j++) mq[i][j] = mq[i][j+1];
                        msz[i]--;
                    end else if (acc && i == 1) begin
                        mout[i] = {if_pc, if_inst};
                        mv[i]   = 1'b1;
                        took    = 1'b1;
                    end else begin
                        mout[i] = '0;
                        mv[i]   = 1'b0;
                    end
                end
                if (acc && !took) begin
                    mq[i][msz[i]] = {if_pc, if_inst};
                    msz[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic          dv, dr;
            logic [AW-1:0] dp;
            logic [IW-1:0] di;
            logic [CW-1:0] dc;
            if (i == 0) begin dv = vld0; dr = rdy0; dp = pc0; di = inst0; dc = cnt0; end
            else        begin dv = vld1; dr = rdy1; dp = pc1; di = inst1; dc = cnt1; end
            chk($sformatf("u%0d.id_valid", i), 64'(dv), 64'(mv[i]));
            chk($sformatf("u%0d.id_pc", i),    64'(dp), 64'(mout[i][63:32]));
            chk($sformatf("u%0d.id_inst", i),  64'(di), 64'(mout[i][31:0]));
            chk($sformatf("u%0d.count", i),    64'(dc), 64'(msz[i]));
            chk($sformatf("u%0d.if_ready", i), 64'(dr), 64'(msz[i] != DEPTH));
        end
    endtask

    // One clock: apply inputs, advance the model, compare just after the edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic fl, input logic r);
        if_valid = v; if_pc = pc; if_inst = ins; id_stall = st; flush = fl; rst = r;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int k;

        // Reset
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst.id_valid", 64'(vld1), 64'd0);
        chk("rst.id_pc",    64'(pc1),  64'd0);
        chk("rst.count",    64'(cnt1), 64'd0);
        chk("rst.if_ready", 64'(rdy1), 64'd1);

        // Single fetch latency
        cyc(1, 32'h100, 32'h3C010001, 0, 0, 0);
        chk("byp1.id_pc",    64'(pc1),   64'h100);
        chk("byp1.id_inst",  64'(inst1), 64'h3C010001);
        chk("byp1.id_valid", 64'(vld1),  64'd1);
        chk("byp1.count",    64'(cnt1),  64'd0);
        chk("byp0.bubble",   64'(vld0),  64'd0);
        chk("byp0.count",    64'(cnt0),  64'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("byp0.id_pc",    64'(pc0),   64'h100);
        chk("byp0.id_inst",  64'(inst0), 64'h3C010001);
        chk("byp0.id_valid", 64'(vld0),  64'd1);
        chk("byp1.after",    64'(vld1),  64'd0);

        // Fill under stall while output holds 0x0FC, then drain
        cyc(1, 32'h0FC, 32'hF0C, 0, 0, 0);
        for (int j = 0; j < 4; j++) cyc(1, 32'h100 + 32'(4*j), 32'hA00 + 32'(j), 1, 0, 0);
        chk("full.count",    64'(cnt1), 64'd4);
        chk("full.if_ready", 64'(rdy1), 64'd0);
        chk("full.hold_pc",  64'(pc1),  64'h0FC);
        cyc(1, 32'h110, 32'hA04, 1, 0, 0);
        chk("full.hold_pc2", 64'(pc1),  64'h0FC);
        chk("full.count2",   64'(cnt1), 64'd4);
        cyc(1, 32'h110, 32'hA04, 0, 0, 0);
        chk("drain.0", 64'(pc1), 64'h100);
        cyc(1, 32'h110, 32'hA04, 0, 0, 0);
        chk("drain.1", 64'(pc1), 64'h104);
        cyc(0, 0, 0, 0, 0, 0);
        chk("drain.2", 64'(pc1), 64'h108);
        cyc(0, 0, 0, 0, 0, 0);
        chk("drain.3", 64'(pc1), 64'h10C);
        cyc(0, 0, 0, 0, 0, 0);
        chk("drain.4", 64'(pc1), 64'h110);
        chk("drain.4inst", 64'(inst1), 64'hA04);
        cyc(0, 0, 0, 0, 0, 0);
        chk("drain.end", 64'(vld1), 64'd0);
        for (int j = 0; j < 4; j++) cyc(0, 0, 0, 0, 0, 0);

        // Wrap-around: 3*DEPTH+1 pushes with alternating stall
        k = 0;
        for (int c = 0; c < 200 && k < 3*DEPTH+1; c++) begin
            logic acc;
            acc = rdy1;
            cyc(1, 32'h1000 + 32'(4*k), 32'h5000 + 32'(k), logic'(c % 2), 0, 0);
            if (acc) k++;
        end
        chk("wrap.pushes", 64'(k), 64'(3*DEPTH+1));
        for (int j = 0; j < 10; j++) cyc(0, 0, 0, 0, 0, 0);

        // Flush with count=3 under stall plus a concurrent fetch
        for (int j = 0; j < 3; j++) cyc(1, 32'h180 + 32'(4*j), 32'h77, 1, 0, 0);
        chk("preflush.count", 64'(cnt1), 64'd3);
        cyc(1, 32'h200, 32'h200, 1, 1, 0);
        chk("flush.count1", 64'(cnt1), 64'd0);
        chk("flush.valid1", 64'(vld1), 64'd0);
        chk("flush.pc1",    64'(pc1),  64'd0);
        chk("flush.count0", 64'(cnt0), 64'd0);
        chk("flush.valid0", 64'(vld0), 64'd0);
        for (int j = 0; j < 3; j++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("postflush.valid", 64'(vld1), 64'd0);
        end
        cyc(1, 32'h300, 32'h301, 0, 0, 0);
        chk("postflush.pc", 64'(pc1), 64'h300);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset with count=2 while push and pop are both active
        cyc(1, 32'h340, 32'h1, 1, 0, 0);
        cyc(1, 32'h344, 32'h2, 1, 0, 0);
        chk("prerst.count", 64'(cnt1), 64'd2);
        cyc(1, 32'h400, 32'h3, 0, 0, 1);
        chk("midrst.valid", 64'(vld1), 64'd0);
        chk("midrst.pc",    64'(pc1),  64'd0);
        chk("midrst.inst",  64'(inst1),64'd0);
        chk("midrst.count", 64'(cnt1), 64'd0);
        chk("midrst.ready", 64'(rdy1), 64'd1);
        for (int j = 0; j < 3; j++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("postrst.valid", 64'(vld1), 64'd0);
        end

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            cyc(logic'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC, $urandom,
                logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 49) == 0),
                logic'($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised IF/ID boundary: a DEPTH-entry circular instruction queue followed by the ID-facing output register. It decouples fetch from decode, so IF keeps fetching while ID is stalled. It inserts zero bubbles when no instruction is available and flushes everything on a redirect (branch or exception). It sits between the IF stage and the ID stage, where the single-entry IF/ID flip-flop stood.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥ 2
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- BYPASS, 1, 1 = when the queue is empty and ID is not stalled, an accepted fetch goes straight to the output register; 0 = every fetch passes through the queue

- clk  input  1  single clock; all state updates on posedge clk
- rst  input  1  synchronous, active-high reset
- if_valid  input  1  IF presents an instruction this cycle
- if_pc  input  ADDR_W  PC of the presented instruction
- if_inst  input  INST_W  presented instruction word
- if_ready  output  1  queue can accept; combinational, equals (count != DEPTH)
- id_stall  input  1  ID holds; the output register must not change
- flush  input  1  discard all queued and output-register contents
- id_valid  output  1  id_pc/id_inst hold a real instruction
- id_pc  output  ADDR_W  PC to ID; zero when bubble
- id_inst  output  INST_W  instruction to ID; zero when bubble
- count  output  $clog2(DEPTH+1)  current queue occupancy; excludes the output register

## Operation
- push = if_valid && if_ready && !flush. A push is never lost. It either writes mem[wr_ptr] or, under the bypass rule, loads the output register.
- Output register update happens only when !id_stall, with priority top-down:
  - count > 0: load mem[rd_ptr]; id_valid=1; pop (rd_ptr+1, mod DEPTH).
  - count == 0, push, BYPASS=1: load if_pc/if_inst; id_valid=1; the entry is not written to the queue.
  - Otherwise: bubble; id_pc=0, id_inst=0, id_valid=0.
- When id_stall=1: the output register holds all three fields, nothing pops, and pushes still write to the queue.
- Queue write: on a push not consumed by bypass, mem[wr_ptr] <= {if_pc, if_inst} and wr_ptr+1 mod DEPTH.
- Occupancy update: count <= count + write − pop. A simultaneous write and pop leaves count unchanged. Writes and pops are legal in the same cycle at any occupancy except full, where if_ready=0 blocks the write.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full and empty are decided from count, never from pointer equality.
- flush (when rst=0):
  - wr_ptr, rd_ptr and count are cleared to 0.
  - The output register is set to a bubble, even if id_stall=1.
  - A concurrent fetch is dropped.
  - mem contents are don't-care.
- rst has priority over flush. It sets:
  - count=0 and both pointers=0;
  - id_pc=0, id_inst=0, id_valid=0;
  - if_ready=1 from the first cycle after reset.
- Reset mid-operation: all queued entries are lost and the behaviour is identical to flush.
- The memory array needs no reset.

## Timing
- Latency from an accepted fetch to ID, for an empty queue with no stall:
  - BYPASS=1: 1 cycle, the same as a plain IF/ID register.
  - BYPASS=0: 2 cycles; a bubble is emitted in the push cycle.
- Throughput: 1 instruction per cycle sustained when neither side stalls. count stays 0 with BYPASS=1 and 1 with BYPASS=0.
- if_ready depends only on registered count. There is no combinational path from id_stall or flush to if_ready.
- id_* outputs are pure registers.
- The cycle after a flush shows a bubble. A fetch accepted in that next cycle follows the normal latency.
- With DEPTH=N and ID stalled, exactly N fetches are accepted; if_ready falls in the cycle after count reaches N. After id_stall is released, one entry drains per cycle in FIFO order.

## Test plan
- Reset, then rst=0 → id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=1.
- BYPASS=1: push pc=0x100, inst=0x3C010001 with no stall → next cycle id_pc=0x100, id_inst=0x3C010001, id_valid=1, count=0. With BYPASS=0, the same values appear one cycle later, preceded by a bubble.
- DEPTH=4: hold id_stall=1 with the output holding pc=0x0FC, and push pc=0x100, 0x104, 0x108, 0x10C, 0x110 on consecutive cycles:
  - the first four are accepted; count=4; if_ready=0; 0x110 is held by IF;
  - the output stays 0x0FC throughout;
  - release the stall → 0x100, 0x104, 0x108, 0x10C, 0x110 appear in order on consecutive cycles.
- Wrap-around: run 3·DEPTH+1 pushes with alternating id_stall → output PCs are strictly in push order and no entry is duplicated or dropped.
- Flush with count=3 and id_stall=1, plus a concurrent push of 0x200 → next cycle count=0, id_valid=0, id_pc=0. The 0x200 fetch is absent from later output.
- Assert rst while count=2 and a push and pop are both active → next cycle all outputs are zero, count=0, if_ready=1. No pre-reset PC ever reaches ID.
